// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and helpers for the pipeline issue controller
package pipe_ctrl_pkg;

  localparam int MIN_L     = 1;
  localparam int MIN_DEPTH = 1;

  // Width able to hold every value 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_result_fifo.sv
// rtl/pipe_result_fifo.sv - result FIFO with modulo-DEPTH pointers and simultaneous read/write when full
module pipe_result_fifo
  import pipe_ctrl_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = 2,
  localparam int CW   = cnt_w(DEPTH),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLR,
  input  logic          WR,
  input  logic [W-1:0]  WDATA,
  input  logic          RD,
  output logic [W-1:0]  RDATA,
  output logic [CW-1:0] COUNT,
  output logic          FULL,
  output logic          EMPTY
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_wr;
  logic          do_rd;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign EMPTY = (COUNT == '0);
  assign FULL  = (COUNT == CW'(DEPTH));
  assign do_rd = RD && !EMPTY;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_wr = WR && (!FULL || do_rd);
  assign RDATA = EMPTY ? '0 : mem[rptr];

  always_ff @(posedge CLK) begin
    if (do_wr && !CLR) begin
      mem[wptr] <= WDATA;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      COUNT <= '0;
    end else if (CLR) begin
      wptr  <= '0;
      rptr  <= '0;
      COUNT <= '0;
    end else begin
      if (do_wr) begin
        wptr <= bump(wptr);
      end
      if (do_rd) begin
        rptr <= bump(rptr);
      end
      unique case ({do_wr, do_rd})
        2'b10:   COUNT <= COUNT + 1'b1;
        2'b01:   COUNT <= COUNT - 1'b1;
        default: COUNT <= COUNT;
      endcase
    end
  end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// rtl/pipe_issue_ctrl.sv - credit-based valid/ready wrapper around a fixed-latency non-stallable pipeline
module pipe_issue_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int W     = 1,
  parameter int L     = 1,
  parameter int DEPTH = L + 1,
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          FLUSH,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [W-1:0]  IN_DATA,
  output logic [W-1:0]  PIPE_A,
  input  logic [W-1:0]  PIPE_B,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [W-1:0]  OUT_DATA,
  output logic [CW-1:0] OCCUPANCY,
  output logic          ERR_OVF
);

  if (L < MIN_L || DEPTH < MIN_DEPTH) begin : g_param_check
    $error("pipe_issue_ctrl: L and DEPTH must both be at least 1");
  end

  logic [L-1:0]  vs;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic          accept;
  logic          emerge;
  logic          fifo_rd;
  logic          fifo_full;
  logic          fifo_empty;

  assign PIPE_A    = IN_DATA;
  // Credits come from registered counts only, so OUT_READY never reaches IN_READY.
  assign IN_READY  = !FLUSH && ((inflight + fifo_count) < CW'(DEPTH));
  assign accept    = IN_VALID && IN_READY;
  assign emerge    = vs[L-1];
  assign OUT_VALID = !fifo_empty;
  assign fifo_rd   = OUT_VALID && OUT_READY;
  assign OCCUPANCY = inflight + fifo_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vs       <= '0;
      inflight <= '0;
    end else if (FLUSH) begin
      vs       <= '0;
      inflight <= '0;
    end else begin
      vs[0] <= accept;
      for (int i = 1; i < L; i++) begin
        vs[i] <= vs[i-1];
      end
      inflight <= inflight + CW'(accept) - CW'(emerge);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERR_OVF <= 1'b0;
    end else if (!FLUSH && emerge && fifo_full && !fifo_rd) begin
      ERR_OVF <= 1'b1;
    end
  end

  pipe_result_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .CLR   (FLUSH),
    .WR    (emerge),
    .WDATA (PIPE_B),
    .RD    (fifo_rd),
    .RDATA (OUT_DATA),
    .COUNT (fifo_count),
    .FULL  (fifo_full),
    .EMPTY (fifo_empty)
  );

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// tb/tb_pipe_issue_ctrl.sv - directed self-checking bench for pipe_issue_ctrl
`timescale 1ns/1ps
module tb_pipe_issue_ctrl;

  localparam int W     = 8;
  localparam int L     = 3;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          CLK;
  logic          RST;
  logic          FLUSH;
  logic          IN_VALID;
  logic          IN_READY;
  logic [W-1:0]  IN_DATA;
  logic [W-1:0]  PIPE_A;
  logic [W-1:0]  PIPE_B;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [W-1:0]  OUT_DATA;
  logic [CW-1:0] OCCUPANCY;
  logic          ERR_OVF;

  logic          f_clr;
  logic          f_wr;
  logic [W-1:0]  f_wdata;
  logic          f_rd;
  logic [W-1:0]  f_rdata;
  logic [CW-1:0] f_count;
  logic          f_full;
  logic          f_empty;

  logic [W-1:0]  pipe_s [L];

  int            n_checks;
  int            n_pass;
  int            n_acc;
  int            n_out;
  int            n_ready_low;
  logic [7:0]    src_q [$];
  logic [7:0]    exp_q [$];
  logic          last_in_ready;
  logic          last_out_valid;
  logic [7:0]    last_out_data;
  logic [CW-1:0] last_occ;
  logic [7:0]    drain_exp [4];

  pipe_issue_ctrl #(.W(W), .L(L), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .FLUSH     (FLUSH),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .PIPE_A    (PIPE_A),
    .PIPE_B    (PIPE_B),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OCCUPANCY (OCCUPANCY),
    .ERR_OVF   (ERR_OVF)
  );

  pipe_result_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .CLR   (f_clr),
    .WR    (f_wr),
    .WDATA (f_wdata),
    .RD    (f_rd),
    .RDATA (f_rdata),
    .COUNT (f_count),
    .FULL  (f_full),
    .EMPTY (f_empty)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // The attached 3-deep delay line.
  always @(posedge CLK) begin
    pipe_s[0] <= PIPE_A;
    for (int i = 1; i < L; i++) pipe_s[i] <= pipe_s[i-1];
  end
  assign PIPE_B = pipe_s[L-1];

  initial begin
    #100000;
    $display("FAIL watchdog: observed time limit reached, expected $finish earlier");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clear_stats();
    n_acc = 0;
    n_out = 0;
    n_ready_low = 0;
  endtask

  // One cycle: drive at posedge+1, sample at negedge, score handshakes.
  task automatic tick(input logic out_rdy);
    IN_VALID  = (src_q.size() != 0);
    IN_DATA   = IN_VALID ? src_q[0] : 8'h00;
    OUT_READY = out_rdy;
    @(negedge CLK);
    last_in_ready  = IN_READY;
    last_out_valid = OUT_VALID;
    last_out_data  = OUT_DATA;
    last_occ       = OCCUPANCY;
    if (IN_VALID && !IN_READY) n_ready_low++;
    if (IN_VALID && IN_READY) begin
      exp_q.push_back(src_q.pop_front());
      n_acc++;
    end
    if (OUT_VALID && OUT_READY) begin
      n_out++;
      if (exp_q.size() == 0) check("out_unexpected", {31'b0, OUT_VALID}, 32'd0);
      else check("out_order", {24'b0, OUT_DATA}, {24'b0, exp_q.pop_front()});
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    RST = 1'b1;
    FLUSH = 1'b0;
    IN_VALID = 1'b0;
    IN_DATA = '0;
    OUT_READY = 1'b0;
    f_clr = 1'b0;
    f_wr = 1'b0;
    f_rd = 1'b0;
    f_wdata = '0;
    clear_stats();

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("reset_in_ready", IN_READY, 1);
    check("reset_out_valid", OUT_VALID, 0);
    check("reset_occupancy", OCCUPANCY, 0);
    check("reset_err_ovf", ERR_OVF, 0);
    check("reset_out_data", OUT_DATA, 0);
    @(posedge CLK);
    #1;

    // Single item: output only in cycle 4, occupancy back to 0 in cycle 5.
    clear_stats();
    src_q = '{8'hA5};
    for (int c = 0; c < 7; c++) begin
      tick(1'b1);
      check("single_out_valid", last_out_valid, (c == 4));
      if (c == 4) check("single_out_data", last_out_data, 8'hA5);
      if (c == 1) check("single_occ_busy", last_occ, 1);
      if (c == 5) check("single_occ_idle", last_occ, 0);
    end

    // Stream 0x01..0x10: four accepts then one credit stall, repeating.
    clear_stats();
    for (int i = 1; i <= 16; i++) src_q.push_back(8'(i));
    repeat (19) tick(1'b1);
    check("stream_accepts", n_acc, 16);
    check("stream_ready_low", n_ready_low, 3);
    repeat (6) tick(1'b1);
    check("stream_outputs", n_out, 16);
    check("stream_pending", exp_q.size(), 0);

    // Backpressure: 4 credits only, then reads release one accept each.
    clear_stats();
    for (int i = 0; i < 16; i++) src_q.push_back(8'h20 + 8'(i));
    repeat (8) tick(1'b0);
    check("bp_accepts", n_acc, 4);
    check("bp_in_ready", last_in_ready, 0);
    check("bp_occupancy", last_occ, 4);
    check("bp_err_ovf", ERR_OVF, 0);
    check("bp_head", last_out_data, 8'h20);
    tick(1'b1);
    check("resume_ready_first", last_in_ready, 0);
    tick(1'b1);
    check("resume_ready_next", last_in_ready, 1);
    for (int k = 0; k < 80 && (src_q.size() != 0 || exp_q.size() != 0); k++) tick(1'b1);
    check("bp_outputs", n_out, 16);
    check("bp_pending", exp_q.size(), 0);

    // Flush with 2 in flight and 2 in the FIFO.
    clear_stats();
    src_q = '{8'hB0, 8'hB1};
    repeat (5) tick(1'b0);
    src_q = '{8'hB2, 8'hB3};
    repeat (2) tick(1'b0);
    check("pre_flush_accepts", n_acc, 4);
    check("pre_flush_occ", last_occ, 3);
    FLUSH = 1'b1;
    src_q = '{8'hB4};
    tick(1'b0);
    check("flush_in_ready", last_in_ready, 0);
    check("flush_occ_before", last_occ, 4);
    FLUSH = 1'b0;
    src_q.delete();
    exp_q.delete();
    n_out = 0;
    tick(1'b1);
    check("post_flush_occ", last_occ, 0);
    check("post_flush_valid", last_out_valid, 0);
    repeat (5) tick(1'b1);
    check("post_flush_stale", n_out, 0);

    // Asynchronous reset mid-stream.
    clear_stats();
    src_q = '{8'hC0, 8'hC1, 8'hC2};
    repeat (6) tick(1'b0);
    check("mid_occ", last_occ, 3);
    check("mid_out_valid", last_out_valid, 1);
    #2 RST = 1'b1;
    #1;
    check("async_rst_occ", OCCUPANCY, 0);
    check("async_rst_out_valid", OUT_VALID, 0);
    check("async_rst_in_ready", IN_READY, 1);
    check("async_rst_err_ovf", ERR_OVF, 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    exp_q.delete();

    // Result FIFO: full with simultaneous read and write, then a dropped write.
    for (int i = 0; i < 4; i++) begin
      f_wr = 1'b1;
      f_wdata = 8'h50 + 8'(i);
      @(posedge CLK);
      #1;
    end
    f_wr = 1'b0;
    @(negedge CLK);
    check("fifo_full_count", f_count, 4);
    check("fifo_full_flag", f_full, 1);
    check("fifo_head", f_rdata, 8'h50);
    @(posedge CLK);
    #1;
    f_wr = 1'b1;
    f_rd = 1'b1;
    f_wdata = 8'h54;
    @(negedge CLK);
    check("fifo_rw_head", f_rdata, 8'h50);
    @(posedge CLK);
    #1;
    f_rd = 1'b0;
    f_wdata = 8'h55;
    @(negedge CLK);
    check("fifo_rw_count", f_count, 4);
    @(posedge CLK);
    #1;
    f_wr = 1'b0;
    @(negedge CLK);
    check("fifo_drop_count", f_count, 4);
    @(posedge CLK);
    #1;
    drain_exp = '{8'h51, 8'h52, 8'h53, 8'h54};
    for (int i = 0; i < 4; i++) begin
      f_rd = 1'b1;
      @(negedge CLK);
      check("fifo_drain", f_rdata, drain_exp[i]);
      @(posedge CLK);
      #1;
    end
    f_rd = 1'b0;
    @(negedge CLK);
    check("fifo_empty_flag", f_empty, 1);
    check("fifo_empty_count", f_count, 0);
    check("final_err_ovf", ERR_OVF, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
